// File: rtl/conv_mover_pkg.sv
// Shared definitions for the GEMM tile data mover: FSM encoding and sizing helpers.
package conv_mover_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoadW  = 3'd1,
        StStream = 3'd2,
        StDrain  = 3'd3,
        StDone   = 3'd4
    } mover_state_e;

    // The array empties PE_SIZE-1 cycles after the last activation enters it.
    localparam int unsigned DrainSkew = 1;

    function automatic int unsigned drain_len(input int unsigned pe_size);
        return pe_size - DrainSkew;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/mover_counter.sv
// Up-counter with synchronous load, enable and terminal-count flag; wraps to 0 after i_last.
module mover_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count register: load beats enable; enabled step at terminal count wraps to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/gemm_tile_data_mover.sv
// Sequences weight-tile loads and activation streaming from two read-only memories into a
// systolic array, one column tile at a time.
module gemm_tile_data_mover
    import conv_mover_pkg::*;
#(
    parameter int unsigned PE_SIZE         = 16,
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned MEM0_ADDR_WIDTH = 10,
    parameter int unsigned MEM1_ADDR_WIDTH = 10,
    parameter int unsigned ROW_NUM         = 70,
    parameter int unsigned TILE_NUM        = 18
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic [MEM0_ADDR_WIDTH-1:0]       w_base_i,
    input  logic [MEM1_ADDR_WIDTH-1:0]       a_base_i,
    input  logic                             stall_i,
    input  logic [DATA_WIDTH-1:0]            mem0_q0_i,
    input  logic [DATA_WIDTH-1:0]            mem1_q0_i,
    output logic [MEM0_ADDR_WIDTH-1:0]       mem0_addr0,
    output logic [MEM1_ADDR_WIDTH-1:0]       mem1_addr0,
    output logic                             mem0_ce0,
    output logic                             mem1_ce0,
    output logic                             mem0_we0,
    output logic                             mem1_we0,
    output logic [DATA_WIDTH-1:0]            w_data_o,
    output logic [DATA_WIDTH-1:0]            a_data_o,
    output logic                             w_valid_o,
    output logic                             wren_o,
    output logic                             rden_o,
    output logic                             sa_en_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [cnt_width(TILE_NUM)-1:0]   tile_idx_o
);

    localparam int unsigned KW = cnt_width(PE_SIZE);
    localparam int unsigned RW = cnt_width(ROW_NUM);
    localparam int unsigned DW = cnt_width(drain_len(PE_SIZE));
    localparam int unsigned TW = cnt_width(TILE_NUM);

    mover_state_e               r_state;
    logic [MEM0_ADDR_WIDTH-1:0] r_w_base;
    logic [MEM1_ADDR_WIDTH-1:0] r_a_base;
    logic                       r_w_valid;
    logic                       r_wren;
    logic                       r_rden;

    logic          w_idle;
    logic [KW-1:0] w_k;
    logic [RW-1:0] w_r;
    logic [DW-1:0] w_d;
    logic [TW-1:0] w_tile;
    logic          w_k_tc;
    logic          w_r_tc;
    logic          w_d_tc;
    logic          w_t_tc;
    logic          w_k_en;
    logic          w_r_en;
    logic          w_d_en;
    logic          w_t_en;

    assign w_idle = (r_state == StIdle);
    assign w_k_en = (r_state == StLoadW);
    assign w_r_en = (r_state == StStream) && !stall_i;
    assign w_d_en = (r_state == StDrain);
    assign w_t_en = w_d_en && w_d_tc && !w_t_tc;

    // All counters are parked at zero while idle, so a start always begins from tile 0.
    mover_counter #(.WIDTH(KW)) u_k_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idle),
        .i_load_val ('0),
        .i_en       (w_k_en),
        .i_last     (KW'(PE_SIZE - 1)),
        .o_count    (w_k),
        .o_tc       (w_k_tc)
    );

    mover_counter #(.WIDTH(RW)) u_r_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idle),
        .i_load_val ('0),
        .i_en       (w_r_en),
        .i_last     (RW'(ROW_NUM - 1)),
        .o_count    (w_r),
        .o_tc       (w_r_tc)
    );

    mover_counter #(.WIDTH(DW)) u_d_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idle),
        .i_load_val ('0),
        .i_en       (w_d_en),
        .i_last     (DW'(drain_len(PE_SIZE) - 1)),
        .o_count    (w_d),
        .o_tc       (w_d_tc)
    );

    mover_counter #(.WIDTH(TW)) u_t_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idle),
        .i_load_val ('0),
        .i_en       (w_t_en),
        .i_last     (TW'(TILE_NUM - 1)),
        .o_count    (w_tile),
        .o_tc       (w_t_tc)
    );

    // Job sequencer; abort overrides every other transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_w_base <= '0;
            r_a_base <= '0;
        end else if (abort_i) begin
            r_state <= StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_state  <= StLoadW;
                        r_w_base <= w_base_i;
                        r_a_base <= a_base_i;
                    end
                end
                StLoadW:  if (w_k_tc) r_state <= StStream;
                StStream: if (w_r_en && w_r_tc) r_state <= StDrain;
                StDrain:  if (w_d_tc) r_state <= w_t_tc ? StDone : StLoadW;
                StDone:   r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    // One-cycle memory read latency: valid strobes trail the chip enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_valid <= 1'b0;
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
        end else begin
            r_w_valid <= mem0_ce0;
            r_wren    <= mem1_ce0;
            r_rden    <= r_wren;
        end
    end

    // Addresses wrap naturally at the port width; held at zero outside their phase.
    assign mem0_addr0 = (r_state == StLoadW)
        ? r_w_base + MEM0_ADDR_WIDTH'(32'(w_tile) * PE_SIZE) + MEM0_ADDR_WIDTH'(w_k)
        : '0;
    assign mem1_addr0 = (r_state == StStream) ? r_a_base + MEM1_ADDR_WIDTH'(w_r) : '0;

    assign mem0_ce0   = w_k_en;
    assign mem1_ce0   = w_r_en;
    assign mem0_we0   = 1'b0;
    assign mem1_we0   = 1'b0;
    assign w_data_o   = mem0_q0_i;
    assign a_data_o   = mem1_q0_i;
    assign w_valid_o  = r_w_valid;
    assign wren_o     = r_wren;
    assign rden_o     = r_rden;
    assign sa_en_o    = r_wren || (r_state == StDrain);
    assign busy_o     = !w_idle;
    assign done_o     = (r_state == StDone);
    assign tile_idx_o = w_tile;

endmodule

// File: tb/tb_gemm_tile_data_mover.sv
// Self-checking bench for gemm_tile_data_mover (PE_SIZE=4, ROW_NUM=6, TILE_NUM=2).
module tb_gemm_tile_data_mover;

    localparam int PE = 4;
    localparam int RN = 6;
    localparam int TN = 2;
    localparam int DWD = 32;
    localparam int MAXC = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i, abort_i, stall_i;
    logic [9:0]      w_base_i, a_base_i;
    logic [DWD-1:0]  mem0_q, mem1_q;
    logic [9:0]      mem0_addr0, mem1_addr0;
    logic            mem0_ce0, mem1_ce0, mem0_we0, mem1_we0;
    logic [DWD-1:0]  w_data_o, a_data_o;
    logic            w_valid_o, wren_o, rden_o, sa_en_o, busy_o, done_o;
    logic [0:0]      tile_idx_o;

    gemm_tile_data_mover #(
        .PE_SIZE(PE), .DATA_WIDTH(DWD), .MEM0_ADDR_WIDTH(10), .MEM1_ADDR_WIDTH(10),
        .ROW_NUM(RN), .TILE_NUM(TN)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .w_base_i(w_base_i), .a_base_i(a_base_i), .stall_i(stall_i),
        .mem0_q0_i(mem0_q), .mem1_q0_i(mem1_q),
        .mem0_addr0(mem0_addr0), .mem1_addr0(mem1_addr0),
        .mem0_ce0(mem0_ce0), .mem1_ce0(mem1_ce0), .mem0_we0(mem0_we0), .mem1_we0(mem1_we0),
        .w_data_o(w_data_o), .a_data_o(a_data_o), .w_valid_o(w_valid_o), .wren_o(wren_o),
        .rden_o(rden_o), .sa_en_o(sa_en_o), .busy_o(busy_o), .done_o(done_o),
        .tile_idx_o(tile_idx_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DWD-1:0] f0(input logic [9:0] a);
        return 32'hC0DE0000 | {22'b0, a};
    endfunction
    function automatic logic [DWD-1:0] f1(input logic [9:0] a);
        return 32'hBEEF0000 | {22'b0, a};
    endfunction

    // Memories with one-cycle read latency.
    always @(posedge clk) begin
        if (mem0_ce0) mem0_q <= f0(mem0_addr0);
        if (mem1_ce0) mem1_q <= f1(mem1_addr0);
    end

    int n_chk = 0;
    int n_fail = 0;

    bit stall_v [MAXC];
    bit e_m0ce [MAXC], e_m1ce [MAXC], e_m1act [MAXC], e_drain [MAXC], e_busy [MAXC];
    bit e_done [MAXC], e_wval [MAXC], e_wren [MAXC], e_rden [MAXC], e_sa [MAXC], e_tchk [MAXC];
    int e_m0a [MAXC], e_m1a [MAXC], e_tile [MAXC];
    bit g_m0, g_m1, g_wren;  // strobe state carried in from the previous job

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    // Expected per-cycle trace built phase by phase from the job's rules.
    task automatic build_model(input int wb, input int ab, input int abort_c, input int rst_c,
                               output int done_c);
        int c;
        int r;
        for (int i = 0; i < MAXC; i++) begin
            e_m0ce[i] = 0; e_m1ce[i] = 0; e_m1act[i] = 0; e_drain[i] = 0; e_busy[i] = 0;
            e_done[i] = 0; e_m0a[i] = 0; e_m1a[i] = 0; e_tile[i] = 0;
        end
        c = 1;
        for (int t = 0; t < TN; t++) begin
            for (int k = 0; k < PE; k++) begin
                e_m0ce[c] = 1; e_m0a[c] = (wb + t * PE + k) % 1024;
                e_tile[c] = t; e_busy[c] = 1; c++;
            end
            r = 0;
            while (r < RN) begin
                e_m1act[c] = 1; e_m1a[c] = (ab + r) % 1024; e_tile[c] = t; e_busy[c] = 1;
                if (!stall_v[c]) begin
                    e_m1ce[c] = 1; r++;
                end
                c++;
            end
            for (int d = 0; d < PE - 1; d++) begin
                e_drain[c] = 1; e_tile[c] = t; e_busy[c] = 1; c++;
            end
        end
        e_done[c] = 1; e_busy[c] = 1; e_tile[c] = TN - 1;
        done_c = c;
        for (int i = 0; i < MAXC; i++) begin
            bit killed;
            killed = (abort_c >= 0 && i > abort_c) || (rst_c >= 0 && i > rst_c);
            if (killed) begin
                e_m0ce[i] = 0; e_m1ce[i] = 0; e_m1act[i] = 0; e_drain[i] = 0;
                e_busy[i] = 0; e_done[i] = 0; e_tile[i] = 0;
            end
            e_tchk[i] = e_busy[i] || (rst_c >= 0 && i > rst_c);
        end
        for (int i = 0; i < MAXC; i++) begin
            e_wval[i] = (i == 0) ? g_m0 : e_m0ce[i-1];
            e_wren[i] = (i == 0) ? g_m1 : e_m1ce[i-1];
            e_rden[i] = (i == 0) ? g_wren : e_wren[i-1];
            if (rst_c >= 0 && i > rst_c) begin
                e_wval[i] = 0; e_wren[i] = 0; e_rden[i] = 0;
            end
            e_sa[i] = e_wren[i] || e_drain[i];
        end
    endtask

    task automatic check_cycle(input int c);
        logic [9:0] exp_ctl;
        logic [9:0] act_ctl;
        exp_ctl = {e_m0ce[c], e_m1ce[c], 2'b00, e_wval[c], e_wren[c], e_rden[c], e_sa[c],
                   e_busy[c], e_done[c]};
        act_ctl = {mem0_ce0, mem1_ce0, mem0_we0, mem1_we0, w_valid_o, wren_o, rden_o, sa_en_o,
                   busy_o, done_o};
        chk("ctrl{ce0,ce1,we0,we1,wval,wren,rden,sa,busy,done}", c, 32'(act_ctl),
            32'(exp_ctl));
        if (e_m0ce[c]) chk("mem0_addr0", c, 32'(mem0_addr0), 32'(e_m0a[c]));
        if (e_m1act[c]) chk("mem1_addr0", c, 32'(mem1_addr0), 32'(e_m1a[c]));
        if (e_tchk[c]) chk("tile_idx_o", c, 32'(tile_idx_o), 32'(e_tile[c]));
        if (c > 0 && e_wval[c]) chk("w_data_o", c, w_data_o, f0(10'(e_m0a[c-1])));
        if (c > 0 && e_wren[c]) chk("a_data_o", c, a_data_o, f1(10'(e_m1a[c-1])));
    endtask

    // Drive one job from cycle 0 (start) and compare every cycle; ncyc 0 means run to done+3.
    task automatic run_job(input int wb, input int ab, input int abort_c, input int rst_c,
                           input int sx0, input int sx1, input int ncyc_in,
                           output int done_seen, output int done_model);
        int ncyc;
        build_model(wb, ab, abort_c, rst_c, done_model);
        ncyc = (ncyc_in == 0) ? done_model + 3 : ncyc_in;
        done_seen = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start_i = (c == 0) || (c == sx0) || (c == sx1);
            stall_i = stall_v[c];
            abort_i = (c == abort_c);
            rst     = (c == rst_c);
            if (c == 0) begin
                w_base_i = 10'(wb); a_base_i = 10'(ab);
            end else begin
                w_base_i = 10'($urandom); a_base_i = 10'($urandom);
            end
            @(negedge clk);
            check_cycle(c);
            if (done_o && done_seen < 0) done_seen = c;
        end
        g_m0 = e_m0ce[ncyc-1]; g_m1 = e_m1ce[ncyc-1]; g_wren = e_wren[ncyc-1];
    endtask

    typedef struct {
        int wb; int ab; int st_lo; int st_hi; int sx0; int sx1; int exp_done;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int ds, dm;
        tbl[0] = '{wb: 0,   ab: 0,    st_lo: -1, st_hi: -1, sx0: -1, sx1: -1, exp_done: 27};
        tbl[1] = '{wb: 0,   ab: 0,    st_lo: 7,  st_hi: 8,  sx0: -1, sx1: -1, exp_done: 29};
        tbl[2] = '{wb: 100, ab: 1020, st_lo: -1, st_hi: -1, sx0: -1, sx1: -1, exp_done: 27};
        tbl[3] = '{wb: 0,   ab: 0,    st_lo: -1, st_hi: -1, sx0: 7,  sx1: 27, exp_done: 27};

        rst = 1'b1; start_i = 0; abort_i = 0; stall_i = 0; w_base_i = '0; a_base_i = '0;
        g_m0 = 0; g_m1 = 0; g_wren = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", -1, {22'b0, mem0_ce0, mem1_ce0, mem0_we0, mem1_we0, w_valid_o,
            wren_o, rden_o, sa_en_o, busy_o, done_o}, 32'd0);
        chk("reset_tile", -1, 32'(tile_idx_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            for (int c = 0; c < MAXC; c++) stall_v[c] = (c >= tbl[i].st_lo && c <= tbl[i].st_hi);
            run_job(tbl[i].wb, tbl[i].ab, -1, -1, tbl[i].sx0, tbl[i].sx1, 0, ds, dm);
            chk("done_cycle", i, 32'(ds), 32'(tbl[i].exp_done));
        end

        // Abort mid-stream, then restart immediately at the following cycle.
        for (int c = 0; c < MAXC; c++) stall_v[c] = 0;
        run_job(0, 0, 7, -1, -1, -1, 9, ds, dm);
        chk("abort_no_done", 7, 32'(ds), 32'hFFFFFFFF);
        run_job(0, 0, -1, -1, -1, -1, 0, ds, dm);
        chk("restart_done_cycle", 9, 32'(ds), 32'd27);

        // Synchronous reset in the middle of the second weight load.
        run_job(0, 0, -1, 15, -1, -1, 18, ds, dm);
        chk("reset_no_done", 15, 32'(ds), 32'hFFFFFFFF);

        // Randomized jobs against the reference trace.
        for (int j = 0; j < 8; j++) begin
            int wb, ab;
            for (int c = 0; c < MAXC; c++) stall_v[c] = (c < 60) && ($urandom_range(0, 3) == 0);
            wb = int'($urandom_range(0, 1023));
            ab = int'($urandom_range(0, 1023));
            run_job(wb, ab, -1, -1, -1, -1, 0, ds, dm);
            chk("rand_done_cycle", j, 32'(ds), 32'(dm));
        end

        @(posedge clk); #1;
        start_i = 0; stall_i = 0; abort_i = 0; rst = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
